// File: rtl/systolic_skew_feeder.sv
// Skews A/B operand slices into a diagonal wavefront for an NxN systolic MAC grid.
// Optional FEEDER_STATS_EN adds bubble_cnt / seq_cnt statistics outputs.
module systolic_skew_feeder #(
    parameter int unsigned N    = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned PIPE = 1,
    parameter int unsigned CW   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_last,
    input  logic [N*DW-1:0] s_a,
    input  logic [N*DW-1:0] s_b,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   k_count,
    output logic            k_ovf
`ifdef FEEDER_STATS_EN
    ,
    output logic [CW-1:0]   bubble_cnt,
    output logic [CW-1:0]   seq_cnt
`endif
);

    localparam int unsigned F  = (N - 1) + (2 * N - 2) * PIPE;
    localparam int unsigned FW = $clog2(F + 1);
    localparam logic [CW-1:0] K_MAX = '1;

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t          state;
    logic [FW-1:0]   fcnt;
    logic            fire_c;
    logic            flush_end_c;
    logic [N*DW-1:0] inj_a_c;
    logic [N*DW-1:0] inj_b_c;

    assign fire_c      = s_valid & s_ready;
    assign flush_end_c = (state == FLUSH) && (fcnt == FW'(F - 1));
    // Zeros (FP32 +0) are injected whenever no beat is accepted.
    assign inj_a_c     = fire_c ? s_a : '0;
    assign inj_b_c     = fire_c ? s_b : '0;

    // Lane i: free-running chain of i+1 registers, giving 1+i cycles of latency.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] a_q [i+1];
        logic [DW-1:0] b_q [i+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= i; j++) begin
                    a_q[j] <= '0;
                    b_q[j] <= '0;
                end
            end else begin
                a_q[0] <= inj_a_c[i*DW +: DW];
                b_q[0] <= inj_b_c[i*DW +: DW];
                for (int j = 1; j <= i; j++) begin
                    a_q[j] <= a_q[j-1];
                    b_q[j] <= b_q[j-1];
                end
            end
        end

        assign a_out[i*DW +: DW] = a_q[i];
        assign b_out[i*DW +: DW] = b_q[i];
    end

    // Sequence control; s_ready/busy/done are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            fcnt    <= '0;
            s_ready <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            k_count <= '0;
            k_ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire_c) begin
                        k_count <= CW'(1);
                        k_ovf   <= 1'b0;
                        busy    <= 1'b1;
                        if (s_last) begin
                            state   <= FLUSH;
                            fcnt    <= '0;
                            s_ready <= 1'b0;
                        end else begin
                            state <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (fire_c) begin
                        if (k_count == K_MAX) k_ovf <= 1'b1;
                        else                  k_count <= k_count + CW'(1);
                        if (s_last) begin
                            state   <= FLUSH;
                            fcnt    <= '0;
                            s_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_end_c) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt + FW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FEEDER_STATS_EN
    // Bubble cycles within a sequence and completed-sequence count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
            seq_cnt    <= '0;
        end else begin
            if (state == IDLE && fire_c) begin
                bubble_cnt <= '0;
            end else if (state == STREAM && !s_valid && bubble_cnt != K_MAX) begin
                bubble_cnt <= bubble_cnt + CW'(1);
            end
            if (flush_end_c) seq_cnt <= seq_cnt + CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed self-checking bench for systolic_skew_feeder (N=4, PIPE=1; second instance with CW=2).
module tb_systolic_skew_feeder;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic [N*DW-1:0] s_a = '0;
    logic [N*DW-1:0] s_b = '0;
    logic            s_ready;
    logic [N*DW-1:0] a_out;
    logic [N*DW-1:0] b_out;
    logic            busy;
    logic            done;
    logic [15:0]     k_count;
    logic            k_ovf;

    logic            v2 = 1'b0;
    logic            l2 = 1'b0;
    logic [N*DW-1:0] a2 = '0;
    logic [N*DW-1:0] b2 = '0;
    logic            ready2;
    logic [N*DW-1:0] a_out2;
    logic [N*DW-1:0] b_out2;
    logic            busy2;
    logic            done2;
    logic [1:0]      k2;
    logic            ovf2;
`ifdef FEEDER_STATS_EN
    logic [15:0]     bubble_cnt;
    logic [15:0]     seq_cnt;
    logic [1:0]      bubble2;
    logic [1:0]      seq2;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.N(4), .DW(32), .PIPE(1), .CW(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
        .s_a(s_a), .s_b(s_b), .a_out(a_out), .b_out(b_out), .busy(busy), .done(done),
        .k_count(k_count), .k_ovf(k_ovf)
`ifdef FEEDER_STATS_EN
        , .bubble_cnt(bubble_cnt), .seq_cnt(seq_cnt)
`endif
    );

    systolic_skew_feeder #(.N(4), .DW(32), .PIPE(1), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(v2), .s_ready(ready2), .s_last(l2),
        .s_a(a2), .s_b(b2), .a_out(a_out2), .b_out(b_out2), .busy(busy2), .done(done2),
        .k_count(k2), .k_ovf(ovf2)
`ifdef FEEDER_STATS_EN
        , .bubble_cnt(bubble2), .seq_cnt(seq2)
`endif
    );

    function automatic logic [31:0] la(int b, int i);
        return (b == 0) ? 32'h0 : 32'h3F80_0000 + 32'(b << 4) + 32'(i);
    endfunction

    function automatic logic [31:0] lb(int b, int i);
        return (b == 0) ? 32'h0 : 32'h4000_0000 + 32'(b << 4) + 32'(i);
    endfunction

    function automatic logic [N*DW-1:0] pa(int b);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = la(b, i);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] pb(int b);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = lb(b, i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready got=%0b exp=1", s_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else passes++;
        checks++; if (a_out !== '0 || b_out !== '0) $display("FAIL reset_data got=%h/%h exp=0", a_out, b_out); else passes++;
        checks++; if (k_count !== 16'd0 || k_ovf !== 1'b0) $display("FAIL reset_k got=%0d/%0b exp=0/0", k_count, k_ovf); else passes++;
    endtask

    // Three back-to-back beats: lane i shows beat b at obs (b-1)+i, done 9 cycles after FLUSH entry.
    task automatic test_basic();
        int sched [16];
        logic [N*DW-1:0] ea, eb;
        for (int t = 0; t < 16; t++) sched[t] = (t < 3) ? t + 1 : 0;
        for (int t = 0; t < 16; t++) begin
            s_valid = (sched[t] != 0);
            s_last  = (sched[t] == 3);
            s_a     = pa(sched[t]);
            s_b     = pb(sched[t]);
            step();
            ea = '0; eb = '0;
            for (int i = 0; i < N; i++) if (t - i >= 0) begin
                ea[i*DW +: DW] = la(sched[t-i], i);
                eb[i*DW +: DW] = lb(sched[t-i], i);
            end
            checks++; if (a_out !== ea) $display("FAIL basic_a t=%0d got=%h exp=%h", t, a_out, ea); else passes++;
            checks++; if (b_out !== eb) $display("FAIL basic_b t=%0d got=%h exp=%h", t, b_out, eb); else passes++;
            checks++; if (done !== (t == 11)) $display("FAIL basic_done t=%0d got=%0b", t, done); else passes++;
            checks++; if (s_ready !== !(t >= 2 && t <= 11)) $display("FAIL basic_ready t=%0d got=%0b", t, s_ready); else passes++;
        end
        checks++; if (k_count !== 16'd3) $display("FAIL basic_k got=%0d exp=3", k_count); else passes++;
    endtask

    // Beats 1,2, two bubbles, beats 3,4 (last): zero gap travels diagonally.
    task automatic test_bubble();
        int sched [20];
        logic [N*DW-1:0] ea, eb;
`ifdef FEEDER_STATS_EN
        logic [15:0] seq0 = seq_cnt;
`endif
        for (int t = 0; t < 20; t++) sched[t] = 0;
        sched[0] = 1; sched[1] = 2; sched[4] = 3; sched[5] = 4;
        for (int t = 0; t < 20; t++) begin
            s_valid = (sched[t] != 0);
            s_last  = (sched[t] == 4);
            s_a     = pa(sched[t]);
            s_b     = pb(sched[t]);
            step();
            ea = '0; eb = '0;
            for (int i = 0; i < N; i++) if (t - i >= 0) begin
                ea[i*DW +: DW] = la(sched[t-i], i);
                eb[i*DW +: DW] = lb(sched[t-i], i);
            end
            checks++; if (a_out !== ea) $display("FAIL bubble_a t=%0d got=%h exp=%h", t, a_out, ea); else passes++;
            checks++; if (b_out !== eb) $display("FAIL bubble_b t=%0d got=%h exp=%h", t, b_out, eb); else passes++;
            checks++; if (done !== (t == 14)) $display("FAIL bubble_done t=%0d got=%0b", t, done); else passes++;
        end
        checks++; if (k_count !== 16'd4) $display("FAIL bubble_k got=%0d exp=4", k_count); else passes++;
`ifdef FEEDER_STATS_EN
        checks++; if (bubble_cnt !== 16'd2) $display("FAIL bubble_cnt got=%0d exp=2", bubble_cnt); else passes++;
        checks++; if (seq_cnt !== seq0 + 16'd1) $display("FAIL bubble_seq got=%0d exp=%0d", seq_cnt, seq0 + 16'd1); else passes++;
`endif
    endtask

    // Single beat with s_last in IDLE: straight to FLUSH, s_ready low for F+1 cycles.
    task automatic test_single();
        int ndone = 0;
        for (int t = 0; t < 13; t++) begin
            s_valid = (t == 0);
            s_last  = (t == 0);
            s_a     = pa((t == 0) ? 9 : 0);
            s_b     = pb((t == 0) ? 9 : 0);
            step();
            if (done === 1'b1) ndone++;
            checks++; if (s_ready !== (t >= 10)) $display("FAIL single_ready t=%0d got=%0b", t, s_ready); else passes++;
            checks++; if (busy !== (t <= 8)) $display("FAIL single_busy t=%0d got=%0b", t, busy); else passes++;
            if (t == 3) begin
                checks++; if (a_out[3*DW +: DW] !== la(9, 3)) $display("FAIL single_lane3 got=%h exp=%h", a_out[3*DW +: DW], la(9, 3)); else passes++;
            end
        end
        checks++; if (ndone != 1) $display("FAIL single_done_count got=%0d exp=1", ndone); else passes++;
        checks++; if (k_count !== 16'd1) $display("FAIL single_k got=%0d exp=1", k_count); else passes++;
    endtask

    // Beat held during FLUSH/DONE is only taken on the first IDLE cycle.
    task automatic test_back_to_back();
        int sched [24];
        logic [N*DW-1:0] ea;
        for (int t = 0; t < 24; t++) sched[t] = 0;
        sched[0] = 5; sched[1] = 6; sched[12] = 7;
        for (int t = 0; t < 24; t++) begin
            s_valid = (t <= 12);
            s_last  = (t >= 1);
            s_a     = pa((t == 0) ? 5 : (t == 1) ? 6 : 7);
            s_b     = pb((t == 0) ? 5 : (t == 1) ? 6 : 7);
            step();
            ea = '0;
            for (int i = 0; i < N; i++) if (t - i >= 0) ea[i*DW +: DW] = la(sched[t-i], i);
            checks++; if (a_out !== ea) $display("FAIL bp_a t=%0d got=%h exp=%h", t, a_out, ea); else passes++;
            checks++; if (done !== (t == 10 || t == 21)) $display("FAIL bp_done t=%0d got=%0b", t, done); else passes++;
            if (t >= 1 && t <= 12) begin
                checks++; if (k_count !== ((t == 12) ? 16'd1 : 16'd2)) $display("FAIL bp_k t=%0d got=%0d", t, k_count); else passes++;
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // Asynchronous reset with data in flight clears outputs and suppresses done.
    task automatic test_reset_mid();
        for (int t = 0; t < 4; t++) begin
            s_valid = (t < 3);
            s_last  = 1'b0;
            s_a     = pa((t < 3) ? t + 1 : 0);
            s_b     = pb((t < 3) ? t + 1 : 0);
            step();
        end
        s_valid = 1'b0;
        checks++; if (a_out[3*DW +: DW] !== la(1, 3)) $display("FAIL rmid_pre got=%h exp=%h", a_out[3*DW +: DW], la(1, 3)); else passes++;
        rst = 1'b0;
        #1;
        checks++; if (a_out !== '0 || b_out !== '0) $display("FAIL rmid_data got=%h/%h exp=0", a_out, b_out); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%0b exp=0", busy); else passes++;
        checks++; if (k_count !== 16'd0) $display("FAIL rmid_k got=%0d exp=0", k_count); else passes++;
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 12; t++) begin
            step();
            checks++; if (done !== 1'b0 || s_ready !== 1'b1 || a_out !== '0) $display("FAIL rmid_after t=%0d done=%0b ready=%0b a=%h", t, done, s_ready, a_out); else passes++;
        end
    endtask

    // CW=2 instance: saturation at 3, sticky overflow cleared by the next first beat.
    task automatic test_saturation();
        for (int t = 0; t < 4; t++) begin
            v2 = 1'b1;
            l2 = (t == 3);
            a2 = pa(t + 1);
            b2 = pb(t + 1);
            step();
            if (t == 2) begin
                checks++; if (k2 !== 2'd3 || ovf2 !== 1'b0) $display("FAIL sat_beat3 got=%0d/%0b exp=3/0", k2, ovf2); else passes++;
            end
        end
        v2 = 1'b0; l2 = 1'b0;
        checks++; if (k2 !== 2'd3 || ovf2 !== 1'b1) $display("FAIL sat_beat4 got=%0d/%0b exp=3/1", k2, ovf2); else passes++;
        for (int c = 0; c < 40 && done2 !== 1'b1; c++) step();
        checks++; if (done2 !== 1'b1) $display("FAIL sat_done_timeout got=%0b exp=1", done2); else passes++;
        step();
        checks++; if (ovf2 !== 1'b1 || ready2 !== 1'b1) $display("FAIL sat_hold got=%0b/%0b exp=1/1", ovf2, ready2); else passes++;
        v2 = 1'b1; l2 = 1'b1; a2 = pa(8); b2 = pb(8);
        step();
        v2 = 1'b0; l2 = 1'b0;
        checks++; if (k2 !== 2'd1 || ovf2 !== 1'b0) $display("FAIL sat_clear got=%0d/%0b exp=1/0", k2, ovf2); else passes++;
        for (int c = 0; c < 40 && done2 !== 1'b1; c++) step();
        checks++; if (done2 !== 1'b1) $display("FAIL sat_done2_timeout got=%0b exp=1", done2); else passes++;
        step();
`ifdef FEEDER_STATS_EN
        checks++; if (seq2 !== 2'd2) $display("FAIL sat_seq got=%0d exp=2", seq2); else passes++;
        checks++; if (bubble2 !== 2'd0) $display("FAIL sat_bubble got=%0d exp=0", bubble2); else passes++;
`endif
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        test_basic();
        test_bubble();
        test_single();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Upstream stage for an NxN grid of FP32 multiply-accumulate PEs.
- Accepts one row-slice of A operands and one column-slice of B operands per beat over a valid/ready handshake.
- Delays lane i by i cycles to form the diagonal wavefront, drives the grid's west (a) and north (b) edges, flushes with zeros after the last beat, and signals completion.

Parameters:
- N, 4, number of lanes (grid edge length), 2..16.
- DW, 32, lane data width (FP32 bit pattern, passed through untouched).
- PIPE, 1, register stages per PE hop; sets flush length.
- CW, 16, beat counter width.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- s_valid  input  1  beat present on s_a/s_b.
- s_ready  output  1  feeder can accept a beat.
- s_last  input  1  final beat of the current K-sequence; qualified by s_valid.
- s_a  input  N*DW  A operands; lane i at bits [i*DW +: DW].
- s_b  input  N*DW  B operands; same packing.
- a_out  output  N*DW  skewed A to grid west edge; lane i delayed i cycles.
- b_out  output  N*DW  skewed B to grid north edge; lane i delayed i cycles.
- busy  output  1  high in STREAM or FLUSH.
- done  output  1  one-cycle pulse when the flush completes.
- k_count  output  CW  beats accepted in the current sequence.
- k_ovf  output  1  sticky; beat counter saturated.

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE; all skew registers, a_out, b_out, k_count, k_ovf, busy and done go to 0; s_ready is 1 after reset.
- Skew path: each lane i is an i-deep register chain (lane 0 is one register, no extra delay), plus one output register per lane.
  - Beat to a_out/b_out latency is 1+i cycles for lane i.
  - Chains advance every cycle unconditionally; the grid is free-running.
- Injection:
  - When s_valid & s_ready, stage 0 of every lane loads s_a/s_b.
  - In every other cycle, stage 0 loads 0x00000000 (FP32 +0, contributes nothing to the accumulation).
  - Bubbles are therefore allowed mid-sequence.
- FSM states: IDLE, STREAM, FLUSH, DONE.
  - IDLE: s_ready=1. An accepted beat goes to STREAM (or directly to FLUSH if s_last=1 on that beat); k_count is loaded with 1.
  - STREAM: s_ready=1; each accepted beat increments k_count. An accepted beat with s_last=1 goes to FLUSH.
  - FLUSH: s_ready=0, zeros injected. A flush counter runs F = (N-1) + (2*N-2)*PIPE cycles, then the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, s_ready=0, then IDLE. k_count holds until the next first beat. k_ovf clears on that first beat.
- busy = (state==STREAM) | (state==FLUSH).
- k_count saturation: saturates at 2^CW-1. An accepted beat at saturation sets k_ovf and leaves k_count unchanged.
- s_valid with s_ready=0 is ignored; the source must hold the beat.
- s_last without s_valid has no effect.
- Reset mid-sequence: all in-flight skew data is discarded immediately (outputs 0) and done is not issued.
- No arithmetic is performed on the data; widths are pass-through.

Optional Feature:
- Macro: FEEDER_STATS_EN.
- Defined:
  - Adds output bubble_cnt [CW], counting STREAM-state cycles with s_valid=0. It saturates, clears on the first beat of a sequence, and resets to 0.
  - Adds output seq_cnt [CW], incremented at each done pulse; it wraps and resets to 0.
- Undefined: neither port nor any counter logic exists; all other behaviour is identical.

Test Plan:
- N=4, reset release, then 3 back-to-back beats with s_a lane i = 0x3F800000+(beat<<4)+i and s_last on beat 3:
  - lane 0 shows beats 1..3 on cycles 1..3 after the first acceptance;
  - lane 3 shows them on cycles 4..6;
  - all other cycles are 0;
  - k_count=3;
  - done pulses exactly F=9 cycles after FLUSH entry (PIPE=1).
- Bubble insertion: 4 beats with s_valid low for 2 cycles between beats 2 and 3 -> a 2-cycle zero gap appears in every lane at its skewed position; k_count=4; no spurious data.
- Single-beat sequence: s_valid=1, s_last=1 in IDLE -> FSM goes straight to FLUSH; s_ready=0 for F+1 cycles; done=1 once; then s_ready=1.
- Backpressure: hold s_valid=1 with a new beat during FLUSH -> not accepted, k_count unchanged; the beat is accepted on the first cycle after DONE, and k_count=1.
- Reset asserted while lane 3 still holds data mid-STREAM -> a_out/b_out = 0 at once; busy=0; no done pulse; s_ready=1 after release.
- CW=2: 4 beats -> k_count saturates at 3 and k_ovf=1 after beat 4; k_ovf clears on the next sequence's first beat. With FEEDER_STATS_EN, the bubble case from scenario 2 gives bubble_cnt=2 and seq_cnt increments by 1 per done.
